fpu_addsub: RTL

FPU_ADDSUB -- requirements
Module: fpu_addsub

---
 rtl/fpu_addsub.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fpu_addsub.sv
// Multi-cycle floating-point adder/subtractor (IDLE/ALIGN/ADD/NORM/ROUND/DONE).
// Define FPU_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated.
module fpu_addsub #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   op_A_in,
  input  logic [EXP_W+MAN_W:0]   op_B_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   data_out,
  output logic [3:0]             status_out,
  output logic [2:0]             state_dbg
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE and out_valid only in DONE, where outputs are held until out_ready.
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int EXT_W = SIG_W + 3;
  localparam int SUM_W = EXT_W + 1;
  localparam int EW    = EXP_W + 2;
  localparam int LZ_W  = $clog2(EXT_W + 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state, state_nxt;

  logic [W-1:0]           a_r, b_r;
  logic                   sub_r, sign_r, eff_sub_r, zero_r;
  logic [EXT_W-1:0]       big_r, small_r, norm_r;
  logic [SUM_W-1:0]       sum_r;
  logic signed [EW-1:0]   exp_r;

  function automatic logic [LZ_W-1:0] lzc(input logic [EXT_W-1:0] v);
    lzc = LZ_W'(EXT_W);
    for (int i = 0; i < EXT_W; i++) begin
      if (v[i]) lzc = LZ_W'(EXT_W - 1 - i);
    end
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ALIGN;
      end
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign state_dbg = state;

  // Alignment: exponent field 0 means zero, so its significand carries no hidden bit.
  logic [EXP_W-1:0]     a_exp, b_exp, big_exp, small_exp, diff;
  logic                 a_sign, b_sign, a_big, big_sign, eff_sub;
  logic [SIG_W-1:0]     a_sig, b_sig, big_sig, small_sig;
  logic [2*EXT_W-1:0]   wide;
  logic [EXT_W-1:0]     aligned;

  always_comb begin
    a_exp     = a_r[W-2 -: EXP_W];
    b_exp     = b_r[W-2 -: EXP_W];
    a_sign    = a_r[W-1];
    b_sign    = b_r[W-1] ^ sub_r;
    a_sig     = (a_exp != '0) ? {1'b1, a_r[MAN_W-1:0]} : '0;
    b_sig     = (b_exp != '0) ? {1'b1, b_r[MAN_W-1:0]} : '0;
    a_big     = (a_r[W-2:0] >= b_r[W-2:0]);
    big_exp   = a_big ? a_exp : b_exp;
    small_exp = a_big ? b_exp : a_exp;
    big_sig   = a_big ? a_sig : b_sig;
    small_sig = a_big ? b_sig : a_sig;
    big_sign  = a_big ? a_sign : b_sign;
    eff_sub   = a_sign ^ b_sign;
    diff      = big_exp - small_exp;
    wide      = {small_sig, 3'b000, {EXT_W{1'b0}}} >> diff;
    if (int'(diff) > MAN_W + 2)
      aligned = {{(EXT_W-1){1'b0}}, |small_sig};
    else
      aligned = {wide[2*EXT_W-1:EXT_W+1], wide[EXT_W] | (|wide[EXT_W-1:0])};
  end

  // Normalisation: carry-out shifts right once, otherwise shift out leading zeros.
  logic [LZ_W-1:0]      lz;
  logic [EXT_W-1:0]     norm_sig;
  logic signed [EW-1:0] norm_exp;

  always_comb begin
    lz = lzc(sum_r[EXT_W-1:0]);
    if (sum_r[SUM_W-1]) begin
      norm_sig = {sum_r[SUM_W-1:2], sum_r[1] | sum_r[0]};
      norm_exp = exp_r + EW'(1);
    end else begin
      norm_sig = sum_r[EXT_W-1:0] << lz;
      norm_exp = exp_r - EW'(lz);
    end
  end

  logic [SIG_W:0]       rounded;
  logic signed [EW-1:0] exp_f;
  logic [MAN_W-1:0]     man_f;
  logic                 inexact;
  logic [W-1:0]         res_data;
  logic [3:0]           res_status;

  always_comb begin
    inexact = |norm_r[2:0];
`ifdef FPU_ROUND_NEAREST_EN
    rounded = {1'b0, norm_r[EXT_W-1:3]}
            + (SIG_W+1)'(norm_r[2] & (norm_r[1] | norm_r[0] | norm_r[3]));
`else
    rounded = {1'b0, norm_r[EXT_W-1:3]};
`endif
    if (rounded[SIG_W]) begin
      exp_f = exp_r + EW'(1);
      man_f = rounded[MAN_W:1];
    end else begin
      exp_f = exp_r;
      man_f = rounded[MAN_W-1:0];
    end
    res_data   = {sign_r, exp_f[EXP_W-1:0], man_f};
    res_status = {inexact, 3'b000};
    if (zero_r) begin
      res_data   = '0;
      res_status = 4'b0001;
    end else if (!exp_f[EW-1] && exp_f > EXP_MAX) begin
      res_data   = {sign_r, {(W-1){1'b1}}};
      res_status = 4'b1010;
    end else if (exp_f[EW-1] || exp_f == '0) begin
      res_data   = '0;
      res_status = 4'b1101;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_r        <= '0;
      b_r        <= '0;
      sub_r      <= 1'b0;
      sign_r     <= 1'b0;
      eff_sub_r  <= 1'b0;
      zero_r     <= 1'b0;
      big_r      <= '0;
      small_r    <= '0;
      norm_r     <= '0;
      sum_r      <= '0;
      exp_r      <= '0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= op_A_in;
          b_r   <= op_B_in;
          sub_r <= op_sub;
        end
        ALIGN: begin
          big_r     <= {big_sig, 3'b000};
          small_r   <= aligned;
          exp_r     <= EW'(big_exp);
          sign_r    <= big_sign;
          eff_sub_r <= eff_sub;
        end
        ADD: sum_r <= eff_sub_r ? ({1'b0, big_r} - {1'b0, small_r})
                                : ({1'b0, big_r} + {1'b0, small_r});
        NORM: begin
          norm_r <= norm_sig;
          exp_r  <= norm_exp;
          zero_r <= (sum_r == '0);
        end
        ROUND: begin
          data_out   <= res_data;
          status_out <= res_status;
          out_valid  <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
